// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates rename tags at decode, captures CDB
// results, commits the head to the register file and flushes on a branch mispredict.
module reorder_buffer #(
  parameter int ROB_SIZE = 15,
  parameter int TAG_W    = 4,
  parameter int REG_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_decode_valid,
  input  logic [REG_W-1:0]  in_decode_rd,
  input  logic              in_decode_is_branch,
  input  logic              in_decode_pred_taken,
  input  logic [31:0]       in_decode_pc,
  output logic [TAG_W-1:0]  out_rob_free_tag,
  output logic              out_rob_full,
  input  logic              in_cdb_valid,
  input  logic [TAG_W-1:0]  in_cdb_tag,
  input  logic [31:0]       in_cdb_value,
  input  logic              in_cdb_taken,
  input  logic [31:0]       in_cdb_target,
  input  logic [TAG_W-1:0]  in_query_tag1,
  input  logic [TAG_W-1:0]  in_query_tag2,
  output logic              out_query_ready1,
  output logic              out_query_ready2,
  output logic [31:0]       out_query_value1,
  output logic [31:0]       out_query_value2,
  output logic [REG_W-1:0]  out_commit_rd,
  output logic [31:0]       out_commit_value,
  output logic [TAG_W-1:0]  out_commit_tag,
  output logic              out_misbranch,
  output logic [31:0]       out_redirect_pc
);

  localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
  localparam int CNT_W = $clog2(ROB_SIZE + 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;
  typedef struct packed {
    logic        ready;
    logic [31:0] value;
  } query_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              busy_q [ROB_SIZE], busy_d [ROB_SIZE];
  logic              ready_q [ROB_SIZE], ready_d [ROB_SIZE];
  logic [REG_W-1:0]  rd_q [ROB_SIZE], rd_d [ROB_SIZE];
  logic              is_branch_q [ROB_SIZE], is_branch_d [ROB_SIZE];
  logic              pred_q [ROB_SIZE], pred_d [ROB_SIZE];
  logic              taken_q [ROB_SIZE], taken_d [ROB_SIZE];
  logic [31:0]       pc_q [ROB_SIZE], pc_d [ROB_SIZE];
  logic [31:0]       value_q [ROB_SIZE], value_d [ROB_SIZE];
  logic [31:0]       target_q [ROB_SIZE], target_d [ROB_SIZE];
  logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
  logic [31:0]       commit_value_q, commit_value_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
  logic              misbranch_q, misbranch_d;
  logic [31:0]       redirect_q, redirect_d;

  logic              alloc_en, cdb_write, commit_en, mispredict;
  logic [IDX_W-1:0]  cdb_idx;
  query_t            query1, query2;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(ROB_SIZE - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
    return (tag != '0) && (tag <= TAG_W'(ROB_SIZE));
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] tag);
    return IDX_W'(tag - TAG_W'(1));
  endfunction

  // A same-cycle CDB broadcast forwards straight to decode's operand lookup.
  function automatic query_t lookup(input logic [TAG_W-1:0] tag);
    query_t res;
    logic   hit;
    res = '0;
    hit = in_cdb_valid && (in_cdb_tag == tag);
    if (tag_in_range(tag)) begin
      res.ready = busy_q[tag_idx(tag)] && (ready_q[tag_idx(tag)] || hit);
      res.value = hit ? in_cdb_value : value_q[tag_idx(tag)];
    end
    return res;
  endfunction

  always_comb begin
    query1 = lookup(in_query_tag1);
    query2 = lookup(in_query_tag2);
  end

  assign out_query_ready1 = query1.ready;
  assign out_query_value1 = query1.value;
  assign out_query_ready2 = query2.ready;
  assign out_query_value2 = query2.value;

  assign out_rob_full     = (count_q == CNT_W'(ROB_SIZE));
  assign out_rob_free_tag = TAG_W'(tail_q) + TAG_W'(1);
  assign out_commit_rd    = commit_rd_q;
  assign out_commit_value = commit_value_q;
  assign out_commit_tag   = commit_tag_q;
  assign out_misbranch    = misbranch_q;
  assign out_redirect_pc  = redirect_q;

  assign cdb_idx    = tag_idx(in_cdb_tag);
  assign cdb_write  = rdy && (state_q == ST_RUN) && in_cdb_valid &&
                      tag_in_range(in_cdb_tag) && busy_q[cdb_idx];
  assign commit_en  = rdy && (state_q == ST_RUN) && busy_q[head_q] && ready_q[head_q];
  assign alloc_en   = rdy && (state_q == ST_RUN) && in_decode_valid && !out_rob_full;
  assign mispredict = is_branch_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

  always_comb begin
    // NOTE: every target gets a default before any branch, so no path leaves a latch.
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    ready_d        = ready_q;
    rd_d           = rd_q;
    is_branch_d    = is_branch_q;
    pred_d         = pred_q;
    taken_d        = taken_q;
    pc_d           = pc_q;
    value_d        = value_q;
    target_d       = target_q;
    commit_rd_d    = '0;
    commit_value_d = '0;
    commit_tag_d   = '0;
    misbranch_d    = 1'b0;
    redirect_d     = redirect_q;

    if (rdy && state_q == ST_FLUSH) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_d[i]  = 1'b0;
        ready_d[i] = 1'b0;
      end
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      misbranch_d = 1'b1;
      state_d     = ST_RUN;
    end else begin
      if (cdb_write) begin
        ready_d[cdb_idx]  = 1'b1;
        value_d[cdb_idx]  = in_cdb_value;
        taken_d[cdb_idx]  = in_cdb_taken;
        target_d[cdb_idx] = in_cdb_target;
      end
      // The mispredicting branch still retires its rd here; the flush follows next cycle.
      if (commit_en) begin
        commit_rd_d     = rd_q[head_q];
        commit_value_d  = value_q[head_q];
        commit_tag_d    = TAG_W'(head_q) + TAG_W'(1);
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = wrap_inc(head_q);
        if (mispredict) begin
          state_d    = ST_FLUSH;
          redirect_d = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
        end
      end
      if (alloc_en) begin
        busy_d[tail_q]      = 1'b1;
        ready_d[tail_q]     = 1'b0;
        rd_d[tail_q]        = in_decode_rd;
        is_branch_d[tail_q] = in_decode_is_branch;
        pred_d[tail_q]      = in_decode_pred_taken;
        pc_d[tail_q]        = in_decode_pc;
        tail_d              = wrap_inc(tail_q);
      end
      count_d = count_q + CNT_W'(alloc_en) - CNT_W'(commit_en);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      misbranch_q    <= 1'b0;
      redirect_q     <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
      end
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      misbranch_q    <= misbranch_d;
      redirect_q     <= redirect_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
    end
  end

  // NOTE: payload storage is left unreset; it is only read while its entry is busy.
  always_ff @(posedge clk) begin
    rd_q        <= rd_d;
    is_branch_q <= is_branch_d;
    pred_q      <= pred_d;
    taken_q     <= taken_d;
    pc_q        <= pc_d;
    value_q     <= value_d;
    target_q    <= target_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: an in-order commit vector table plus
// hand-written sequences for full/wrap, forwarding, flush, stall and reset.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        dec_valid, dec_branch, dec_pred;
  logic [4:0]  dec_rd;
  logic [31:0] dec_pc;
  logic [3:0]  free_tag;
  logic        full;
  logic        cdb_valid, cdb_taken;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_target;
  logic [3:0]  q_tag1, q_tag2;
  logic        q_ready1, q_ready2;
  logic [31:0] q_value1, q_value2;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  commit_tag;
  logic        misbranch;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_SIZE(15), .TAG_W(4), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_decode_valid(dec_valid), .in_decode_rd(dec_rd),
    .in_decode_is_branch(dec_branch), .in_decode_pred_taken(dec_pred),
    .in_decode_pc(dec_pc),
    .out_rob_free_tag(free_tag), .out_rob_full(full),
    .in_cdb_valid(cdb_valid), .in_cdb_tag(cdb_tag), .in_cdb_value(cdb_value),
    .in_cdb_taken(cdb_taken), .in_cdb_target(cdb_target),
    .in_query_tag1(q_tag1), .in_query_tag2(q_tag2),
    .out_query_ready1(q_ready1), .out_query_ready2(q_ready2),
    .out_query_value1(q_value1), .out_query_value2(q_value2),
    .out_commit_rd(commit_rd), .out_commit_value(commit_value),
    .out_commit_tag(commit_tag), .out_misbranch(misbranch),
    .out_redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        dv;
    logic [4:0]  rd;
    logic        cv;
    logic [3:0]  ctag;
    logic [31:0] cval;
    logic [3:0]  exp_free;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val;
    logic [3:0]  exp_tag;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dec_valid = 1'b0; dec_rd = '0; dec_branch = 1'b0; dec_pred = 1'b0; dec_pc = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_taken = 1'b0; cdb_target = '0;
    q_tag1 = '0; q_tag2 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One branch retires; checks the commit, then the flush (or lack of it) a cycle later.
  task automatic branch_seq(input logic [31:0] pc, input logic pred, input logic tk,
                            input logic [31:0] tgt, input logic exp_mis,
                            input logic [31:0] exp_redir, input logic [3:0] exp_free);
    do_reset();
    dec_valid = 1'b1; dec_rd = 5'd1; dec_branch = 1'b1; dec_pred = pred; dec_pc = pc;
    step();
    clear_inputs();
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = pc + 32'd4; cdb_taken = tk; cdb_target = tgt;
    step();
    clear_inputs();
    step();
    check("br_commit_rd", 32'(commit_rd), 32'd1);
    check("br_commit_val", commit_value, pc + 32'd4);
    check("br_commit_tag", 32'(commit_tag), 32'd1);
    check("br_no_early_flush", 32'(misbranch), 32'd0);
    dec_valid = 1'b1; dec_rd = 5'd9;
    step();
    clear_inputs();
    check("br_misbranch", 32'(misbranch), 32'(exp_mis));
    if (exp_mis) check("br_redirect", redirect_pc, exp_redir);
    check("br_flush_no_commit", 32'(commit_rd), 32'd0);
    check("br_free_after", 32'(free_tag), 32'(exp_free));
    check("br_full_after", 32'(full), 32'd0);
    step();
    check("br_pulse_one_cycle", 32'(misbranch), 32'd0);
  endtask

  initial begin
    rdy = 1'b1;
    //           dv    rd     cv    ctag   cval        free   exp_rd exp_val     exp_tag
    vecs[0] = '{1'b1, 5'd5, 1'b0, 4'd0, 32'h0,      4'd1, 5'd0, 32'h0,      4'd0};
    vecs[1] = '{1'b1, 5'd6, 1'b0, 4'd0, 32'h0,      4'd2, 5'd0, 32'h0,      4'd0};
    vecs[2] = '{1'b1, 5'd7, 1'b0, 4'd0, 32'h0,      4'd3, 5'd0, 32'h0,      4'd0};
    vecs[3] = '{1'b0, 5'd0, 1'b1, 4'd3, 32'h3333,   4'd4, 5'd0, 32'h0,      4'd0};
    vecs[4] = '{1'b0, 5'd0, 1'b1, 4'd1, 32'h1111,   4'd4, 5'd0, 32'h0,      4'd0};
    vecs[5] = '{1'b0, 5'd0, 1'b1, 4'd2, 32'h2222,   4'd4, 5'd5, 32'h1111,   4'd1};
    vecs[6] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,      4'd4, 5'd6, 32'h2222,   4'd2};
    vecs[7] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,      4'd4, 5'd7, 32'h3333,   4'd3};
    vecs[8] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,      4'd4, 5'd0, 32'h0,      4'd0};

    do_reset();
    check("rst_commit_rd", 32'(commit_rd), 32'd0);
    check("rst_commit_val", commit_value, 32'd0);
    check("rst_commit_tag", 32'(commit_tag), 32'd0);
    check("rst_misbranch", 32'(misbranch), 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_free_tag", 32'(free_tag), 32'd1);

    // In-order commit with out-of-order completion.
    for (int i = 0; i < 9; i++) begin
      dec_valid = vecs[i].dv; dec_rd = vecs[i].rd;
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ctag; cdb_value = vecs[i].cval;
      #1;
      check($sformatf("v%0d_free_tag", i), 32'(free_tag), 32'(vecs[i].exp_free));
      step();
      clear_inputs();
      check($sformatf("v%0d_commit_rd", i), 32'(commit_rd), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_commit_val", i), commit_value, vecs[i].exp_val);
      check($sformatf("v%0d_commit_tag", i), 32'(commit_tag), 32'(vecs[i].exp_tag));
    end

    // Fill to capacity, refuse the 16th, free one slot, wrap to tag 1.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      dec_valid = 1'b1; dec_rd = 5'(i + 1);
      step();
    end
    #1;
    check("full_after_15", 32'(full), 32'd1);
    check("full_free_wrapped", 32'(free_tag), 32'd1);
    step();
    clear_inputs();
    check("full_16th_ignored", 32'(full), 32'd1);
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'hA1;
    step();
    clear_inputs();
    step();
    check("full_commit_tag", 32'(commit_tag), 32'd1);
    check("full_commit_rd", 32'(commit_rd), 32'd1);
    check("full_commit_val", commit_value, 32'hA1);
    check("full_drops", 32'(full), 32'd0);
    check("wrap_free_tag", 32'(free_tag), 32'd1);
    dec_valid = 1'b1; dec_rd = 5'd20;
    step();
    clear_inputs();
    check("wrap_full_again", 32'(full), 32'd1);
    check("wrap_free_next", 32'(free_tag), 32'd2);

    // Operand lookup with same-cycle CDB forwarding.
    q_tag1 = 4'd4; q_tag2 = 4'd0;
    cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_value = 32'hDEADBEEF;
    #1;
    check("q_fwd_ready", 32'(q_ready1), 32'd1);
    check("q_fwd_value", q_value1, 32'hDEADBEEF);
    check("q_tag0_ready", 32'(q_ready2), 32'd0);
    check("q_tag0_value", q_value2, 32'd0);
    q_tag2 = 4'd5;
    #1;
    check("q_pending_ready", 32'(q_ready2), 32'd0);
    step();
    clear_inputs();
    q_tag1 = 4'd4;
    #1;
    check("q_stored_ready", 32'(q_ready1), 32'd1);
    check("q_stored_value", q_value1, 32'hDEADBEEF);

    // Mispredicted taken branch, mispredicted not-taken branch, correct prediction.
    branch_seq(32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 4'd1);
    branch_seq(32'h300, 1'b1, 1'b0, 32'h900, 1'b1, 32'h304, 4'd1);
    branch_seq(32'h500, 1'b1, 1'b1, 32'h600, 1'b0, 32'h0,   4'd3);

    // rdy low freezes a ready head; it commits exactly once when rdy returns.
    do_reset();
    dec_valid = 1'b1; dec_rd = 5'd3;
    step();
    clear_inputs();
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'h55;
    step();
    clear_inputs();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_commit_rd", i), 32'(commit_rd), 32'd0);
    end
    rdy = 1'b1;
    step();
    check("stall_commit_rd", 32'(commit_rd), 32'd3);
    check("stall_commit_val", commit_value, 32'h55);
    check("stall_commit_tag", 32'(commit_tag), 32'd1);
    step();
    check("stall_no_repeat", 32'(commit_rd), 32'd0);

    // Reset while FLUSH is pending.
    do_reset();
    dec_valid = 1'b1; dec_rd = 5'd2; dec_branch = 1'b1; dec_pred = 1'b0; dec_pc = 32'h40;
    step();
    clear_inputs();
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'h44; cdb_taken = 1'b1; cdb_target = 32'h80;
    step();
    clear_inputs();
    step();
    check("rf_commit_rd", 32'(commit_rd), 32'd2);
    rst = 1'b1;
    step();
    check("rf_misbranch", 32'(misbranch), 32'd0);
    check("rf_full", 32'(full), 32'd0);
    check("rf_free_tag", 32'(free_tag), 32'd1);
    rst = 1'b0;
    step();
    check("rf_no_late_flush", 32'(misbranch), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue for the Tomasulo core.
- Decode allocates one entry per cycle and receives a rename tag, which it writes into the register file's per-register tag.
- Execution units post results on the CDB.
- The head entry commits in order to the register file's write port (index/value/tag). On a branch mispredict the block drives the flush (`misbranch`) that clears all rename tags.

Parameters:
- ROB_SIZE, 15: number of entries. Tag = entry index + 1; tag 0 means "no rename".
- TAG_W, 4: tag width; must satisfy 2^TAG_W > ROB_SIZE.
- REG_W, 5: architectural register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; all state frozen when low
- in_decode_valid  in  1  allocate an entry this cycle
- in_decode_rd  in  REG_W  destination register (0 = none)
- in_decode_is_branch  in  1  entry is a conditional branch or jump
- in_decode_pred_taken  in  1  predictor's direction
- in_decode_pc  in  32  instruction PC
- out_rob_free_tag  out  TAG_W  tag the next allocation will receive (combinational)
- out_rob_full  out  1  no free entry (combinational)
- in_cdb_valid  in  1  result broadcast
- in_cdb_tag  in  TAG_W  producing entry
- in_cdb_value  in  32  result, or link value for jumps
- in_cdb_taken  in  1  resolved branch direction
- in_cdb_target  in  32  resolved taken target
- in_query_tag1, in_query_tag2  in  TAG_W  operand tags being looked up by decode
- out_query_ready1, out_query_ready2  out  1  value available (combinational)
- out_query_value1, out_query_value2  out  32  that value
- out_commit_rd  out  REG_W  register written this cycle (0 = no commit)
- out_commit_value  out  32  committed value
- out_commit_tag  out  TAG_W  tag of the committing entry
- out_misbranch  out  1  one-cycle flush pulse
- out_redirect_pc  out  32  fetch restart PC, valid with out_misbranch

Behaviour:
- Reset:
  - all entries not busy; head = tail = 0; count = 0; state = RUN.
  - out_commit_rd/value/tag = 0; out_misbranch = 0; out_redirect_pc = 0.
- rdy low: no state change. The registered outputs commit_* and misbranch drive 0, so no commit is ever pulsed twice.
- Full/free tag: out_rob_full = (count == ROB_SIZE). out_rob_free_tag = tail + 1.
- Allocate:
  - Condition: in_decode_valid and not full and state = RUN.
  - The entry at tail becomes busy with ready = 0 and stores rd, is_branch, pred_taken, pc.
  - tail wraps from ROB_SIZE-1 to 0.
  - in_decode_valid while full, or while in FLUSH, is ignored.
- CDB write: if in_cdb_valid, in_cdb_tag != 0, and entry (tag-1) is busy, set ready = 1 and latch value, taken, target. Writes to non-busy entries or tag 0 are dropped.
- Query:
  - ready = tag != 0 and the entry is busy and (ready, or a same-cycle CDB hit on that tag).
  - value = the CDB value on a same-cycle hit, else the stored value.
  - tag 0 returns ready = 0, value = 0.
- State RUN, commit. When the head entry is busy and ready (as registered at the start of the cycle):
  - Register outputs commit_rd = rd, commit_value = value, commit_tag = head + 1.
  - Clear the entry and advance head with wrap.
  - Otherwise commit_rd = 0, commit_value = 0, commit_tag = 0.
  - At most one commit per cycle. Allocate and commit in the same cycle leave count unchanged.
- Mispredict detection: a committing branch with taken != pred_taken still commits rd normally, then goes to FLUSH. Redirect = target if taken, else pc + 4, latched.
  - The rd commit and the flush must be in separate cycles because the register file ignores commits while misbranch is high.
- State FLUSH (one rdy-high cycle):
  - out_misbranch = 1 with the latched redirect; commit outputs 0.
  - All entries cleared; head = tail = count = 0; allocation refused.
  - Next state RUN.
- Correctly predicted branches commit like any other entry.
- The CDB entry that completes the head in cycle N commits in cycle N+1, visible on the outputs at N+2.
- rst has priority over everything, including mid-FLUSH; returns to RUN with the queue empty.

Test Plan:
- Reset, then alloc 3 entries (rd = 5, 6, 7); CDB writes tags 3, 1, 2 in successive cycles -> commits rd 5, 6, 7 in order with tags 1, 2, 3; no commit before tag 1 is ready.
- Alloc 15 entries -> out_rob_full = 1 and a 16th valid is ignored. Commit one -> full drops. The next alloc receives tag 1 (wrap).
- Query tag 4 in the same cycle the CDB broadcasts tag 4 value 0xDEADBEEF -> ready = 1, value 0xDEADBEEF. Query tag 0 -> ready = 0.
- Branch pc 0x100, pred_taken = 0, resolved taken target 0x200, rd = 1, link 0x104 -> the commit of rd 1 = 0x104 precedes by one cycle the misbranch pulse with redirect 0x200. Afterwards count = 0 and the next alloc gets tag 1.
- Head ready with rdy held low 3 cycles -> no commit and no repeated pulse. Commit appears after rdy rises.
- Assert rst while in FLUSH -> misbranch 0 next cycle, full 0, free_tag 1.
